ternary_neuron_seq: RTL and testbench

- Sequencer for one ternary neuron built around a single shared 24-input popcount unit, either exact or an evolved approximate popcount24 variant.
- Takes a CHUNKS×24-bit activation vector one chunk at a time.
- Per chunk, time-multiplexes the popcount unit over the positive-weight mask, then the negative-weight mask, and accumulates the signed difference.
- At end of vector, thresholds the sum into a ternary output.
- The popcount instance sits outside this block, so exact and approximate variants can be swapped without touching the controller.

---
 rtl/ternary_neuron_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_ternary_neuron_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_seq.sv
// ---------------------------------------------------------------------------
// ternary_neuron_seq
//
// Controller for one ternary neuron. It takes a CHUNKS x 24-bit activation
// vector one chunk at a time. For every chunk it runs a shared external
// popcount unit twice: first over the positive-weight mask, then over the
// negative-weight mask. The signed difference goes into a saturating
// accumulator. After the last chunk, the sum is compared against two
// thresholds to give a ternary activation. The popcount lives outside this
// block, so an exact or an approximate popcount can be plugged in without
// changing the controller.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cfg_we, cfg_addr    write strobe and chunk index for a weight-mask write
//   cfg_wpos, cfg_wneg  positive / negative weight masks for that chunk
//   cfg_thr_we          threshold write strobe
//   cfg_thr_hi/lo       signed upper / lower thresholds
//   cfg_busy            a vector is in progress or a result is pending
//   s_valid/s_ready     activation chunk handshake, s_data = chunk
//   pc_in / pc_out      operand to, and same-cycle result from, the popcount
//   m_valid/m_ready     result handshake
//   m_sum               signed sum(pos) - sum(neg)
//   m_act               01 = +1, 00 = 0, 11 = -1
// ---------------------------------------------------------------------------
module ternary_neuron_seq #(
    parameter int  CHUNKS = 4,
    parameter int  PC_W   = 5,
    parameter int  ACC_W  = 8,
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [23:0]      cfg_wpos,
    input  logic [23:0]      cfg_wneg,
    input  logic             cfg_thr_we,
    input  logic [ACC_W-1:0] cfg_thr_hi,
    input  logic [ACC_W-1:0] cfg_thr_lo,
    output logic             cfg_busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [23:0]      s_data,
    output logic [23:0]      pc_in,
    input  logic [PC_W-1:0]  pc_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_sum,
    output logic [1:0]       m_act
);

    typedef enum logic [1:0] {IDLE, POS, NEG, OUT} state_t;

    // The arithmetic width is wide enough that one add or subtract can never
    // wrap before the clamp.
    localparam int EXT_W = ACC_W + PC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(CHUNKS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [1:0]              act_q, act_d;
    logic [23:0]             xr_q, xr_d;
    logic [23:0]             wpos_q [CHUNKS];
    logic [23:0]             wneg_q [CHUNKS];
    logic signed [ACC_W-1:0] thrHi_q, thrLo_q;

    logic                    busy;
    logic                    addrOk;
    logic                    lastChunk;
    logic                    sReady;
    logic                    mValid;
    logic [23:0]             pcOperand;
    logic signed [EXT_W-1:0] accExt, pcExt, sumExt;
    logic signed [ACC_W-1:0] accSat;

    // A partially accumulated vector counts as busy even while the FSM waits
    // in IDLE for the next chunk. This stops a weight write in the middle of
    // a vector.
    assign busy      = (state_q != IDLE) || (idx_q != '0);
    assign addrOk    = (int'(cfg_addr) < CHUNKS);
    assign lastChunk = (idx_q == LAST_IDX);

    // Configuration storage. Writes are dropped while busy. A write in the
    // same cycle that the first chunk is accepted still takes effect,
    // because the masks are read only in POS and NEG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHUNKS; i++) begin
                wpos_q[i] <= '0;
                wneg_q[i] <= '0;
            end
            thrHi_q <= '0;
            thrLo_q <= '0;
        end else begin
            if (cfg_we && !busy && addrOk) begin
                wpos_q[cfg_addr] <= cfg_wpos;
                wneg_q[cfg_addr] <= cfg_wneg;
            end
            if (cfg_thr_we && !busy) begin
                thrHi_q <= $signed(cfg_thr_hi);
                thrLo_q <= $signed(cfg_thr_lo);
            end
        end
    end

    // Popcount operand. This sits apart from the next-state logic, so the
    // external pc_in -> pc_out path does not fold back into one process.
    always_comb begin
        pcOperand = '0;
        case (state_q)
            POS:     pcOperand = xr_q & wpos_q[idx_q];
            NEG:     pcOperand = xr_q & wneg_q[idx_q];
            default: pcOperand = '0;
        endcase
    end

    // Saturating accumulate. pc_out is treated as unsigned and is subtracted
    // during the NEG phase.
    always_comb begin
        accExt = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        pcExt  = {{(EXT_W-PC_W){1'b0}}, pc_out};
        sumExt = (state_q == NEG) ? (accExt - pcExt) : (accExt + pcExt);
        if (sumExt > SAT_MAX) begin
            accSat = ACC_MAX;
        end else if (sumExt < SAT_MIN) begin
            accSat = ACC_MIN;
        end else begin
            accSat = sumExt[ACC_W-1:0];
        end
    end

    // Next-state and handshake logic. In NEG, a new chunk can be taken
    // directly so back-to-back chunks cost two cycles each. If no chunk is
    // offered, the FSM parks in IDLE with idx and acc held.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        xr_d    = xr_q;
        sum_d   = sum_q;
        act_d   = act_q;
        sReady  = 1'b0;
        mValid  = 1'b0;
        case (state_q)
            IDLE: begin
                sReady = 1'b1;
                if (s_valid) begin
                    xr_d    = s_data;
                    state_d = POS;
                end
            end
            POS: begin
                acc_d   = accSat;
                state_d = NEG;
            end
            NEG: begin
                acc_d = accSat;
                if (lastChunk) begin
                    sum_d = accSat;
                    // The upper threshold is tested first, so +1 wins when
                    // the two thresholds overlap.
                    if (accSat >= thrHi_q) begin
                        act_d = 2'b01;
                    end else if (accSat <= thrLo_q) begin
                        act_d = 2'b11;
                    end else begin
                        act_d = 2'b00;
                    end
                    state_d = OUT;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    sReady = 1'b1;
                    if (s_valid) begin
                        xr_d    = s_data;
                        state_d = POS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OUT: begin
                mValid = 1'b1;
                if (m_ready) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. The result registers only change on the NEG->OUT
    // transition, so m_sum and m_act stay stable while m_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            xr_q    <= '0;
            sum_q   <= '0;
            act_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            xr_q    <= xr_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
        end
    end

    assign cfg_busy = busy;
    assign s_ready  = sReady;
    assign m_valid  = mValid;
    assign pc_in    = pcOperand;
    assign m_sum    = sum_q;
    assign m_act    = act_q;

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// ---------------------------------------------------------------------------
// tb_ternary_neuron_seq
//
// Self-checking bench for ternary_neuron_seq. The main instance (ACC_W=8)
// uses an exact popcount. A second instance (ACC_W=6) runs in lockstep on
// the same inputs. Its popcount stub returns 31 for any non-zero operand,
// which drives that accumulator into both saturation limits.
// ---------------------------------------------------------------------------
module tb_ternary_neuron_seq;

    localparam int CHUNKS = 4;
    localparam int PC_W   = 5;
    localparam int ACC_W  = 8;
    localparam int SAT_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [23:0]       cfg_wpos, cfg_wneg;
    logic              cfg_thr_we;
    logic [ACC_W-1:0]  cfg_thr_hi, cfg_thr_lo;
    logic              cfg_busy;
    logic              s_valid, s_ready;
    logic [23:0]       s_data;
    logic [23:0]       pc_in;
    logic [PC_W-1:0]   pc_out;
    logic              m_valid, m_ready;
    logic [ACC_W-1:0]  m_sum;
    logic [1:0]        m_act;

    logic              satBusy, satSReady, satMValid;
    logic [23:0]       satPcIn;
    logic [PC_W-1:0]   satPcOut;
    logic [SAT_W-1:0]  satMSum;
    logic [1:0]        satMAct;

    typedef struct {
        logic [23:0]        wpos;
        logic [23:0]        wneg;
        logic signed [7:0]  thrHi;
        logic signed [7:0]  thrLo;
        logic [3:0][23:0]   data;
        bit                 gap;
        logic signed [7:0]  expSum;
        logic [1:0]         expAct;
    } vec_t;

    typedef struct {
        logic signed [7:0]  sum;
        logic [1:0]         act;
        bit                 chkSat;
        logic signed [5:0]  satSum;
        logic [1:0]         satAct;
    } exp_t;

    vec_t vecs [7];
    exp_t sbq [$];
    int   nCompared = 0;
    int   nFailed   = 0;
    int   cycleCnt  = 0;
    int   lastAccept = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    assign pc_out   = PC_W'($countones(pc_in));
    assign satPcOut = (satPcIn != 24'd0) ? 5'd31 : 5'd0;

    ternary_neuron_seq #(.CHUNKS(CHUNKS), .PC_W(PC_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wpos(cfg_wpos), .cfg_wneg(cfg_wneg),
        .cfg_thr_we(cfg_thr_we), .cfg_thr_hi(cfg_thr_hi), .cfg_thr_lo(cfg_thr_lo),
        .cfg_busy(cfg_busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pc_in(pc_in), .pc_out(pc_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_act(m_act)
    );

    ternary_neuron_seq #(.CHUNKS(CHUNKS), .PC_W(PC_W), .ACC_W(SAT_W)) dutSat (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wpos(cfg_wpos), .cfg_wneg(cfg_wneg),
        .cfg_thr_we(cfg_thr_we), .cfg_thr_hi(cfg_thr_hi[SAT_W-1:0]), .cfg_thr_lo(cfg_thr_lo[SAT_W-1:0]),
        .cfg_busy(satBusy),
        .s_valid(s_valid), .s_ready(satSReady), .s_data(s_data),
        .pc_in(satPcIn), .pc_out(satPcOut),
        .m_valid(satMValid), .m_ready(m_ready), .m_sum(satMSum), .m_act(satMAct)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic compareValue(input string name, input logic signed [31:0] got,
                                input logic signed [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        nCompared++;
        nFailed++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    // All stimulus tasks return one time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWeights(input logic [23:0] wp, input logic [23:0] wn);
        for (int a = 0; a < CHUNKS; a++) begin
            cfg_we   = 1'b1;
            cfg_addr = 2'(a);
            cfg_wpos = wp;
            cfg_wneg = wn;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic writeThresholds(input logic signed [7:0] hi, input logic signed [7:0] lo);
        cfg_thr_we = 1'b1;
        cfg_thr_hi = hi;
        cfg_thr_lo = lo;
        tick();
        cfg_thr_we = 1'b0;
    endtask

    // Offer one chunk and wait for it to be accepted. s_valid is left high.
    task automatic sendChunk(input logic [23:0] d);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                lastAccept = cycleCnt;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) reportTimeout("chunkAccept");
    endtask

    task automatic pushExp(input logic signed [7:0] sum, input logic [1:0] act, input bit chk,
                           input logic signed [5:0] satSum, input logic [1:0] satAct);
        exp_t e;
        e.sum    = sum;
        e.act    = act;
        e.chkSat = chk;
        e.satSum = satSum;
        e.satAct = satAct;
        sbq.push_back(e);
    endtask

    task automatic sendVector(input logic [23:0] d0, input logic [23:0] d1,
                              input logic [23:0] d2, input logic [23:0] d3);
        sendChunk(d0);
        sendChunk(d1);
        sendChunk(d2);
        sendChunk(d3);
        s_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        writeWeights(v.wpos, v.wneg);
        writeThresholds(v.thrHi, v.thrLo);
        for (int c = 0; c < CHUNKS; c++) begin
            sendChunk(v.data[c]);
            if (v.gap && c != CHUNKS - 1) begin
                s_valid = 1'b0;
                repeat (2) tick();
            end
        end
        s_valid = 1'b0;
        pushExp(v.expSum, v.expAct, 1'b0, 6'sd0, 2'b00);
    endtask

    // Wait for a result, compare it with the scoreboard head, optionally hold
    // off m_ready for a while (offering a chunk meanwhile), then consume it.
    task automatic checkOutput(input int holdCycles);
        bit   seen = 1'b0;
        exp_t e;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            reportTimeout("resultValid");
            if (sbq.size() > 0) void'(sbq.pop_front());
            tick();
            return;
        end
        compareValue("latency", cycleCnt - lastAccept, 3);
        if (sbq.size() == 0) begin
            reportTimeout("scoreboardEntry");
            tick();
            return;
        end
        e = sbq.pop_front();
        compareValue("m_sum", 32'($signed(m_sum)), 32'(e.sum));
        compareValue("m_act", 32'(m_act), 32'(e.act));
        if (e.chkSat) begin
            compareValue("satValid", 32'(satMValid), 1);
            compareValue("satSum", 32'($signed(satMSum)), 32'(e.satSum));
            compareValue("satAct", 32'(satMAct), 32'(e.satAct));
        end
        for (int h = 0; h < holdCycles; h++) begin
            s_valid = 1'b1;
            s_data  = 24'hABCDEF;
            @(posedge clk);
            @(negedge clk);
            compareValue("holdValid", 32'(m_valid), 1);
            compareValue("holdSReady", 32'(s_ready), 0);
            compareValue("holdSum", 32'($signed(m_sum)), 32'(e.sum));
            compareValue("holdAct", 32'(m_act), 32'(e.act));
            compareValue("holdPcIn", 32'(pc_in), 0);
            compareValue("holdBusy", 32'(cfg_busy), 1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        compareValue("afterValid", 32'(m_valid), 0);
        compareValue("afterBusy", 32'(cfg_busy), 0);
        compareValue("afterSReady", 32'(s_ready), 1);
        tick();
    endtask

    task automatic setVec(input int i, input logic [23:0] wp, input logic [23:0] wn,
                          input logic signed [7:0] hi, input logic signed [7:0] lo,
                          input logic [23:0] d0, input logic [23:0] d1,
                          input logic [23:0] d2, input logic [23:0] d3, input bit gap,
                          input logic signed [7:0] es, input logic [1:0] ea);
        vecs[i].wpos    = wp;
        vecs[i].wneg    = wn;
        vecs[i].thrHi   = hi;
        vecs[i].thrLo   = lo;
        vecs[i].data[0] = d0;
        vecs[i].data[1] = d1;
        vecs[i].data[2] = d2;
        vecs[i].data[3] = d3;
        vecs[i].gap     = gap;
        vecs[i].expSum  = es;
        vecs[i].expAct  = ea;
    endtask

    // Watchdog so the run always ends even if the DUT locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] readyPat;

        setVec(0, 24'hFFFFFF, 24'h000000, 8'sd10, -8'sd10,
               24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 8'sd96, 2'b01);
        setVec(1, 24'h000000, 24'h0000FF, 8'sd10, -8'sd10,
               24'h0000F0, 24'h0000F0, 24'h0000F0, 24'h0000F0, 1'b1, -8'sd16, 2'b11);
        setVec(2, 24'h0F0F0F, 24'hF0F0F0, 8'sd10, -8'sd10,
               24'hFFFFFF, 24'h000000, 24'h0F0000, 24'hFF00FF, 1'b0, 8'sd4, 2'b00);
        setVec(3, 24'h0F0F0F, 24'hF0F0F0, -8'sd5, 8'sd5,
               24'hFFFFFF, 24'h000000, 24'h0F0000, 24'hFF00FF, 1'b1, 8'sd4, 2'b01);
        setVec(4, 24'h0F0F0F, 24'hF0F0F0, 8'sd5, 8'sd4,
               24'hFFFFFF, 24'h000000, 24'h0F0000, 24'hFF00FF, 1'b0, 8'sd4, 2'b11);
        setVec(5, 24'h0F0F0F, 24'hF0F0F0, 8'sd4, -8'sd10,
               24'hFFFFFF, 24'h000000, 24'h0F0000, 24'hFF00FF, 1'b1, 8'sd4, 2'b01);
        setVec(6, 24'h800001, 24'h7FFFFE, 8'sd0, 8'sd0,
               24'hFFFFFF, 24'h800000, 24'h000001, 24'h123456, 1'b0, -8'sd27, 2'b11);

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wpos = '0; cfg_wneg = '0;
        cfg_thr_we = 1'b0; cfg_thr_hi = '0; cfg_thr_lo = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        compareValue("rstSReady", 32'(s_ready), 1);
        compareValue("rstMValid", 32'(m_valid), 0);
        compareValue("rstMSum", 32'($signed(m_sum)), 0);
        compareValue("rstMAct", 32'(m_act), 0);
        compareValue("rstPcIn", 32'(pc_in), 0);
        compareValue("rstBusy", 32'(cfg_busy), 0);
        compareValue("rstSatSReady", 32'(satSReady), 1);
        compareValue("rstSatBusy", 32'(satBusy), 0);
        compareValue("rstSatMValid", 32'(satMValid), 0);
        #2 rst = 1'b0;
        tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput((i == 1) ? 5 : 0);
        end

        $display("[TB] back-to-back s_ready pattern");
        writeWeights(24'hFFFFFF, 24'h000000);
        writeThresholds(8'sd0, 8'sd0);
        readyPat = 9'b001010101;
        s_valid = 1'b1;
        s_data  = 24'h000FFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            compareValue($sformatf("readyPat%0d", i), 32'(s_ready), 32'(readyPat[i]));
            if (s_ready) lastAccept = cycleCnt;
            tick();
        end
        s_valid = 1'b0;
        pushExp(8'sd48, 2'b01, 1'b0, 6'sd0, 2'b00);
        checkOutput(0);

        $display("[TB] saturation");
        writeWeights(24'hFFFFFF, 24'h000000);
        writeThresholds(8'sd0, 8'sd0);
        sendVector(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        pushExp(8'sd96, 2'b01, 1'b1, 6'sd31, 2'b01);
        checkOutput(0);
        writeWeights(24'h000000, 24'hFFFFFF);
        sendVector(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        pushExp(-8'sd96, 2'b11, 1'b1, -6'sd32, 2'b11);
        checkOutput(0);

        $display("[TB] configuration while busy");
        writeWeights(24'hFFFFFF, 24'h000000);
        writeThresholds(8'sd100, -8'sd100);
        sendChunk(24'hFFFFFF);
        s_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        compareValue("busyMidVector", 32'(cfg_busy), 1);
        writeWeights(24'h000000, 24'hFFFFFF);
        writeThresholds(8'sd0, 8'sd0);
        sendChunk(24'hFFFFFF);
        sendChunk(24'hFFFFFF);
        sendChunk(24'hFFFFFF);
        s_valid = 1'b0;
        pushExp(8'sd96, 2'b00, 1'b0, 6'sd0, 2'b00);
        checkOutput(0);
        writeWeights(24'h000000, 24'hFFFFFF);
        writeThresholds(8'sd0, 8'sd0);
        sendVector(24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F);
        pushExp(-8'sd16, 2'b11, 1'b0, 6'sd0, 2'b00);
        checkOutput(0);

        $display("[TB] reset mid-vector");
        writeWeights(24'hFFFFFF, 24'h000000);
        writeThresholds(8'sd50, 8'sd40);
        sendChunk(24'hFFFFFF);
        sendChunk(24'hFFFFFF);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        compareValue("midRstMValid", 32'(m_valid), 0);
        compareValue("midRstSReady", 32'(s_ready), 1);
        compareValue("midRstBusy", 32'(cfg_busy), 0);
        #3 rst = 1'b0;
        tick();
        sendVector(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        pushExp(8'sd0, 2'b01, 1'b1, 6'sd0, 2'b01);
        checkOutput(0);

        compareValue("scoreboardLeftover", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
